// File: rtl/irq_pending_capture_if.sv
// Avalon-MM register port of irq_pending_capture: word-addressed, registered read
// data with a one-cycle readdatavalid strobe.
interface irq_pending_capture_if;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport slave (
      input  address, read, write, writedata,
      output readdata, readdatavalid
   );

   modport master (
      output address, read, write, writedata,
      input  readdata, readdatavalid
   );
endinterface

// File: rtl/irq_pending_capture.sv
// Interrupt conditioning ahead of the vector-compute stage: per-bit level/edge capture,
// enable mask and Avalon-MM control. Define IRQ_PENDING_SYNC_EN to add a 2-flop input synchronizer.
module irq_pending_capture #(
   parameter logic [31:0] EDGE_MASK     = 32'h0000_0000,
   parameter logic [31:0] IENABLE_RESET = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 irq,
   irq_pending_capture_if.slave        avs,
   output logic [31:0]                 ipending,
   output logic                        irq_out
);

   typedef enum logic [1:0] {
      REG_PEND    = 2'd0,
      REG_IENABLE = 2'd1,
      REG_EDGECAP = 2'd2,
      REG_IPEND   = 2'd3
   } reg_addr_t;

   logic [31:0] irq_s;
   logic [31:0] irq_d;
   logic [31:0] pend_reg;
   logic [31:0] pend_next;
   logic [31:0] ienable;
   logic [31:0] clr;
   logic [31:0] read_mux;
   reg_addr_t   addr;

   assign addr = reg_addr_t'(avs.address);

`ifdef IRQ_PENDING_SYNC_EN
   logic [31:0] sync_q1;
   logic [31:0] sync_q2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq;
         sync_q2 <= sync_q1;
      end
   end

   assign irq_s = sync_q2;
`else
   // Without the synchronizer irq must already be synchronous to clk.
   assign irq_s = irq;
`endif

   assign clr = (avs.write && addr == REG_EDGECAP) ? avs.writedata : 32'h0;

   // Edge bits: a new rising edge overrides a clear in the same cycle.
   assign pend_next = (~EDGE_MASK & irq_s)
                    | ( EDGE_MASK & ((pend_reg & ~clr) | (irq_s & ~irq_d)));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, which is what gives the read-returns-old-value behaviour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_d    <= '0;
         pend_reg <= '0;
         ienable  <= IENABLE_RESET;
      end else begin
         irq_d    <= irq_s;
         pend_reg <= pend_next;
         if (avs.write && addr == REG_IENABLE)
            ienable <= avs.writedata;
      end
   end

   assign ipending = pend_reg & ienable;
   assign irq_out  = |ipending;

   // NOTE: read_mux is assigned on every path through the case, so no latch is inferred.
   always_comb begin
      read_mux = '0;
      unique case (addr)
         REG_PEND:    read_mux = pend_reg;
         REG_IENABLE: read_mux = ienable;
         REG_EDGECAP: read_mux = pend_reg & EDGE_MASK;
         REG_IPEND:   read_mux = ipending;
         default:     read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avs.readdata      <= '0;
         avs.readdatavalid <= 1'b0;
      end else begin
         avs.readdatavalid <= avs.read;
         if (avs.read)
            avs.readdata <= read_mux;
      end
   end

endmodule

// File: tb/tb_irq_pending_capture.sv
// Directed bench for irq_pending_capture: vector table for level/mask/register-map
// behaviour plus hand sequences for edge capture, set-vs-clear, read/write overlap and reset.
module tb_irq_pending_capture;

`ifdef IRQ_PENDING_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   localparam logic [31:0] EDGE_MASK     = 32'h0000_0100;
   localparam logic [31:0] IENABLE_RESET = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] irq;
   logic [31:0] ipending;
   logic        irq_out;

   irq_pending_capture_if avs ();

   irq_pending_capture #(
      .EDGE_MASK     (EDGE_MASK),
      .IENABLE_RESET (IENABLE_RESET)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .irq      (irq),
      .avs      (avs),
      .ipending (ipending),
      .irq_out  (irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] irq;
      logic [1:0]  addr;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_ipending;
      logic        exp_irq_out;
      logic        exp_rdv;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      avs.address   = 2'd0;
      avs.read      = 1'b0;
      avs.write     = 1'b0;
      avs.writedata = 32'h0;
   endtask

   task automatic bus_set(input logic [1:0] a, input logic r, input logic w, input logic [31:0] d);
      avs.address   = a;
      avs.read      = r;
      avs.write     = w;
      avs.writedata = d;
   endtask

   // Extra idle cycles before the checked edge let an irq change reach pend_reg
   // at the same edge as the bus operation, whatever the input latency.
   task automatic apply_row(input int idx, input vec_t v);
      irq = v.irq;
      bus_idle();
      repeat (LAT - 1) tick();
      bus_set(v.addr, v.rd, v.wr, v.wdata);
      tick();
      check($sformatf("row%0d ipending", idx), ipending, v.exp_ipending);
      check($sformatf("row%0d irq_out", idx), {31'h0, irq_out}, {31'h0, v.exp_irq_out});
      check($sformatf("row%0d readdatavalid", idx), {31'h0, avs.readdatavalid}, {31'h0, v.exp_rdv});
      check($sformatf("row%0d readdata", idx), avs.readdata, v.exp_rdata);
      bus_idle();
   endtask

   initial begin
      //            irq           addr rd  wr  wdata         ipend          out  rdv  rdata
      vecs[0]  = '{32'h0000_0000, 2'd1, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000};
      vecs[1]  = '{32'h0000_0000, 2'd0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_0000};
      vecs[2]  = '{32'h0000_0000, 2'd1, 0, 1, 32'h0000_0005, 32'h0000_0000, 0, 0, 32'h0000_0000};
      vecs[3]  = '{32'h0000_0004, 2'd0, 0, 0, 32'h0000_0000, 32'h0000_0004, 1, 0, 32'h0000_0000};
      vecs[4]  = '{32'h0000_0004, 2'd0, 1, 0, 32'h0000_0000, 32'h0000_0004, 1, 1, 32'h0000_0004};
      vecs[5]  = '{32'h0000_0000, 2'd0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_0004};
      vecs[6]  = '{32'h0000_0008, 2'd1, 0, 1, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_0004};
      vecs[7]  = '{32'h0000_0008, 2'd0, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0008};
      vecs[8]  = '{32'h0000_0008, 2'd3, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000};
      vecs[9]  = '{32'h0000_0008, 2'd1, 0, 1, 32'h0000_0008, 32'h0000_0008, 1, 0, 32'h0000_0000};
      vecs[10] = '{32'h0000_0008, 2'd2, 1, 0, 32'h0000_0000, 32'h0000_0008, 1, 1, 32'h0000_0000};
      vecs[11] = '{32'h0000_0008, 2'd0, 0, 1, 32'hFFFF_FFFF, 32'h0000_0008, 1, 0, 32'h0000_0000};
      vecs[12] = '{32'h0000_0008, 2'd2, 0, 1, 32'h0000_0008, 32'h0000_0008, 1, 0, 32'h0000_0000};
      vecs[13] = '{32'h0000_0008, 2'd1, 1, 0, 32'h0000_0000, 32'h0000_0008, 1, 1, 32'h0000_0008};

      reset = 1'b1;
      irq   = 32'h0;
      bus_idle();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("reset ipending", ipending, 32'h0);
      check("reset irq_out", {31'h0, irq_out}, 32'h0);
      check("reset readdatavalid", {31'h0, avs.readdatavalid}, 32'h0);

      for (int i = 0; i < 14; i++) apply_row(i, vecs[i]);

      // Switch to the edge bit: enable only bit 8, drop all lines and let them settle.
      irq = 32'h0;
      bus_set(2'd1, 1'b0, 1'b1, 32'h0000_0100);
      tick();
      bus_idle();
      repeat (LAT) tick();
      check("edge idle ipending", ipending, 32'h0);

      // One-cycle pulse on irq[8] is captured and held.
      irq = 32'h0000_0100;
      tick();
      irq = 32'h0;
      repeat (LAT) tick();
      check("pulse captured ipending", ipending, 32'h0000_0100);
      check("pulse captured irq_out", {31'h0, irq_out}, 32'h1);
      repeat (3) tick();
      check("pulse held ipending", ipending, 32'h0000_0100);
      bus_set(2'd2, 1'b1, 1'b0, 32'h0);
      tick();
      bus_idle();
      check("edgecap read", avs.readdata, 32'h0000_0100);
      bus_set(2'd2, 1'b0, 1'b1, 32'h0000_0100);
      tick();
      bus_idle();
      check("edge cleared ipending", ipending, 32'h0);
      check("edge cleared irq_out", {31'h0, irq_out}, 32'h0);

      // New rising edge in the same cycle as a clear: set wins.
      irq = 32'h0000_0100;
      repeat (LAT - 1) tick();
      bus_set(2'd2, 1'b0, 1'b1, 32'h0000_0100);
      tick();
      bus_idle();
      check("set wins ipending", ipending, 32'h0000_0100);
      tick();
      check("set wins held", ipending, 32'h0000_0100);
      // Line still high but no new edge, so the clear now takes effect.
      bus_set(2'd2, 1'b0, 1'b1, 32'h0000_0100);
      tick();
      bus_idle();
      check("clear while high ipending", ipending, 32'h0);
      irq = 32'h0;
      repeat (LAT) tick();

      // Same-cycle read and write of IENABLE returns the old mask.
      bus_set(2'd1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      tick();
      bus_idle();
      check("rw overlap readdata", avs.readdata, 32'h0000_0100);
      check("rw overlap readdatavalid", {31'h0, avs.readdatavalid}, 32'h1);
      bus_set(2'd1, 1'b1, 1'b0, 32'h0);
      tick();
      check("new mask readdata", avs.readdata, 32'hFFFF_FFFF);
      check("back-to-back readdatavalid", {31'h0, avs.readdatavalid}, 32'h1);

      // Reset mid-read drops readdatavalid immediately and restores the mask.
      #2;
      reset = 1'b1;
      #1;
      check("mid-read reset readdatavalid", {31'h0, avs.readdatavalid}, 32'h0);
      check("mid-read reset readdata", avs.readdata, 32'h0);
      tick();
      check("in reset readdatavalid", {31'h0, avs.readdatavalid}, 32'h0);
      reset = 1'b0;
      tick();
      check("after reset readdata", avs.readdata, IENABLE_RESET);
      check("after reset readdatavalid", {31'h0, avs.readdatavalid}, 32'h1);
      bus_idle();
      tick();
      check("after reset rdv low", {31'h0, avs.readdatavalid}, 32'h0);
      check("after reset ipending", ipending, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_pending_capture.md
Name: irq_pending_capture

Overview:
- Upstream stage of the interrupt-vector custom instruction.
- Conditions raw peripheral interrupt lines (optional synchronizer, per-bit level or edge capture), applies a software-controlled enable mask and drives the 32-bit ipending word consumed by the vector-compute stage.
- Provides a small Avalon-MM slave for mask control, edge-capture clear and status readback.

Parameters:
- EDGE_MASK, 32'h0000_0000, per-bit select: 1 = bit i is edge-captured (rising), 0 = bit i is level-sensitive.
- IENABLE_RESET, 32'h0000_0000, reset value of the ienable mask register.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- irq  input  32  raw interrupt request lines, active-high.
- address  input  2  Avalon-MM slave word address.
- read  input  1  Avalon-MM read strobe.
- write  input  1  Avalon-MM write strobe.
- writedata  input  32  Avalon-MM write data.
- readdata  output  32  Avalon-MM read data, registered.
- readdatavalid  output  1  high for one cycle when readdata is valid.
- ipending  output  32  pend_reg & ienable; feeds the vector-compute stage.
- irq_out  output  1  OR-reduction of ipending.

Behaviour:
- Reset (asynchronous, active-high) clears these to 0: sync stages, irq_d, pend_reg, readdata and readdatavalid.
- Reset loads ienable = IENABLE_RESET.
- ipending and irq_out follow from pend_reg & ienable, so both are 0 out of reset unless IENABLE_RESET and pending bits say otherwise.
- irq_s is the conditioned input: the synchronizer output (see Optional Feature) or raw irq.
- irq_d <= irq_s every cycle. Because irq_d resets to 0, a line that is high when reset is released counts as a rising edge.
- Level bit i (EDGE_MASK[i]=0): pend_reg[i] <= irq_s[i] every cycle. The bit is not affected by clear writes.
- Edge bit i (EDGE_MASK[i]=1): pend_reg[i] <= (pend_reg[i] & ~clr[i]) | (irq_s[i] & ~irq_d[i]).
  - clr[i] = write & (address==2) & writedata[i].
  - If a new edge and a clear occur in the same cycle, set wins and the bit stays 1.
- ipending = pend_reg & ienable (combinational from registers). irq_out = |ipending.
- Latency without the synchronizer: irq rises before edge N; pend_reg is updated at edge N; ipending is valid after edge N (1 cycle).
- Register map (word address):
  - 0 PEND: read returns pend_reg. Writes are ignored.
  - 1 IENABLE: read/write. A write updates ienable at the next edge, so ipending reflects the new mask in the cycle after the write.
  - 2 EDGECAP: read returns pend_reg & EDGE_MASK. Write-1-to-clear on edge bits only; level bits are ignored.
  - 3 IPEND: read returns ipending. Writes are ignored.
- Read timing:
  - A read sampled at edge N gives readdata and readdatavalid=1 after edge N, for one cycle.
  - readdatavalid is 0 in all other cycles, and readdata holds its last value.
- Same-cycle read and write: the read returns the pre-write value of every register.
- Back-to-back reads are supported at one per cycle with no wait states.
- Reset asserted mid-operation: all state returns to reset values immediately, and any pending readdatavalid is dropped.

Optional Feature:
- Macro: IRQ_PENDING_SYNC_EN.
- Defined: each irq bit passes through a 2-flop synchronizer (reset 0), and irq_s is the second-stage output.
  - End-to-end latency is 3 cycles from irq rising before edge N to ipending valid after edge N+2.
  - Pulses shorter than one clock may be lost.
- Not defined: irq_s = irq directly, with 1-cycle latency. irq must then be synchronous to clk.

Test Plan:
- Reset release with IENABLE_RESET=32'h0, irq=32'h0 -> ipending=0, irq_out=0, readdatavalid=0; reading address 1 returns 32'h0 with readdatavalid one cycle after the read.
- EDGE_MASK=0, write IENABLE=32'h0000_0005, drive irq=32'h0000_0004 -> ipending=32'h4 and irq_out=1 after 1 cycle (3 with the macro); drop irq -> ipending=0 on the following cycle.
- EDGE_MASK=32'h0000_0100, IENABLE=32'h100, one-cycle pulse on irq[8] -> ipending=32'h100 and it stays set; write 32'h100 to address 2 -> ipending=0 the next cycle.
- EDGE_MASK=32'h100: new rising edge on irq[8] in the same cycle as a clear write of 32'h100 -> pend_reg[8] remains 1.
- Level irq[3]=1 with IENABLE=0 -> PEND reads 32'h8 and IPEND reads 0; write IENABLE=32'h8 -> irq_out=1 the cycle after the write.
- Same-cycle read of address 1 and write of 32'hFFFF_FFFF to address 1 -> readdata returns the old mask; a later read returns 32'hFFFF_FFFF. Assert reset mid-read -> readdatavalid=0 and ienable=IENABLE_RESET.
